// File: rtl/rwave_fifo_ctrl.sv
// rwave_fifo_ctrl: sequencer for the 8-bank R-wave sample FIFO datapath.
// Owns the row write/read pointers and occupancy, arbitrates the shared
// row address between the row writer and the sample reader, keeps the read
// enable asserted across back-to-back row bursts and flags valid samples.
//
// Optional feature macro: RWAVE_FIFO_CTRL_WR_PRIO_EN
//   defined   : a pending write breaks a read burst at the next row boundary
//   undefined : a read burst runs until rd_req drops or the FIFO empties
module rwave_fifo_ctrl #(
    parameter int NUM_OF_MEM     = 8,
    parameter int MEM_DEPTH      = 128,
    parameter int LOG2_MEM_DEPTH = 7
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      wr_req,
    output logic                      wr_ack,
    input  logic                      rd_req,
    output logic [LOG2_MEM_DEPTH-1:0] fifo_addr,
    output logic                      fifo_w_en,
    output logic                      fifo_r_en,
    input  logic                      fifo_r_inc,
    output logic                      sample_valid,
    output logic [LOG2_MEM_DEPTH:0]   count,
    output logic                      full,
    output logic                      empty,
    output logic                      busy
);

    localparam int                        BEAT_W    = (NUM_OF_MEM > 1) ? $clog2(NUM_OF_MEM) : 1;
    localparam logic [BEAT_W-1:0]         BEAT_LAST = BEAT_W'(NUM_OF_MEM - 1);
    localparam logic [LOG2_MEM_DEPTH:0]   DEPTH_CNT = (LOG2_MEM_DEPTH + 1)'(MEM_DEPTH);
    localparam logic [LOG2_MEM_DEPTH-1:0] PTR_LAST  = LOG2_MEM_DEPTH'(MEM_DEPTH - 1);

`ifdef RWAVE_FIFO_CTRL_WR_PRIO_EN
    localparam bit WR_PRIO = 1'b1;
`else
    localparam bit WR_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                    state;
    logic [LOG2_MEM_DEPTH-1:0] wr_ptr;
    logic [LOG2_MEM_DEPTH-1:0] rd_ptr;
    logic [BEAT_W-1:0]         beat;
    logic [LOG2_MEM_DEPTH:0]   count_dec;
    logic                      row_end;
    logic                      more_rows;

    // Row pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [LOG2_MEM_DEPTH-1:0] next_ptr(input logic [LOG2_MEM_DEPTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A row ends on the datapath's last-bank pulse; the beat counter is a
    // backstop so a lost r_inc cannot leave the read enable stuck high.
    assign row_end   = (state == READ) && (fifo_r_inc || (beat == BEAT_LAST));
    assign count_dec = count - 1'b1;
    assign more_rows = rd_req && (count_dec != '0) && !(WR_PRIO && wr_req);

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign busy  = (state != IDLE);

    // Sequencer: state, pointers, occupancy and registered datapath controls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            beat         <= '0;
            fifo_addr    <= '0;
            fifo_w_en    <= 1'b0;
            fifo_r_en    <= 1'b0;
            wr_ack       <= 1'b0;
            sample_valid <= 1'b0;
        end else if (clr) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            beat         <= '0;
            fifo_addr    <= '0;
            fifo_w_en    <= 1'b0;
            fifo_r_en    <= 1'b0;
            wr_ack       <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (wr_req && !full) begin
                        state     <= WRITE;
                        fifo_w_en <= 1'b1;
                        wr_ack    <= 1'b1;
                        fifo_addr <= wr_ptr;
                    end else if (rd_req && !empty) begin
                        // First beat only launches the bank-0 read; no data yet.
                        state        <= READ;
                        fifo_r_en    <= 1'b1;
                        fifo_addr    <= rd_ptr;
                        sample_valid <= 1'b0;
                    end
                end
                WRITE: begin
                    wr_ptr    <= next_ptr(wr_ptr);
                    count     <= count + 1'b1;
                    state     <= IDLE;
                    fifo_w_en <= 1'b0;
                    wr_ack    <= 1'b0;
                    fifo_addr <= '0;
                end
                READ: begin
                    // Every later read beat (and DRAIN) returns the previous bank.
                    sample_valid <= 1'b1;
                    if (row_end) begin
                        rd_ptr    <= next_ptr(rd_ptr);
                        count     <= count_dec;
                        beat      <= '0;
                        fifo_addr <= next_ptr(rd_ptr);
                        if (!more_rows) begin
                            state <= DRAIN;
                        end
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DRAIN: begin
                    state        <= IDLE;
                    fifo_r_en    <= 1'b0;
                    sample_valid <= 1'b0;
                    fifo_addr    <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rwave_fifo_ctrl.sv
// tb_rwave_fifo_ctrl: directed bench for rwave_fifo_ctrl with a small model
// of the datapath's one-hot bank sequencer driving fifo_r_inc.
module tb_rwave_fifo_ctrl;

    logic       clk;
    logic       reset_n;
    logic       clr;
    logic       wr_req;
    logic       wr_ack;
    logic       rd_req;
    logic [6:0] fifo_addr;
    logic       fifo_w_en;
    logic       fifo_r_en;
    logic       fifo_r_inc;
    logic       sample_valid;
    logic [7:0] count;
    logic       full;
    logic       empty;
    logic       busy;

    logic [2:0] bank;
    int         tests;
    int         failed;

`ifdef RWAVE_FIFO_CTRL_WR_PRIO_EN
    localparam int EXP_ACK_CYC = 11;
    localparam int EXP_RESUME  = 1;
`else
    localparam int EXP_ACK_CYC = 27;
    localparam int EXP_RESUME  = 3;
`endif

    rwave_fifo_ctrl #(
        .NUM_OF_MEM(8),
        .MEM_DEPTH(128),
        .LOG2_MEM_DEPTH(7)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clr(clr),
        .wr_req(wr_req),
        .wr_ack(wr_ack),
        .rd_req(rd_req),
        .fifo_addr(fifo_addr),
        .fifo_w_en(fifo_w_en),
        .fifo_r_en(fifo_r_en),
        .fifo_r_inc(fifo_r_inc),
        .sample_valid(sample_valid),
        .count(count),
        .full(full),
        .empty(empty),
        .busy(busy)
    );

    initial clk = 1'b0;
    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Datapath bank sequencer: steps one bank per read-enabled cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       bank <= 3'd0;
        else if (!fifo_r_en) bank <= 3'd0;
        else                bank <= bank + 3'd1;
    end
    assign fifo_r_inc = fifo_r_en && (bank == 3'd7);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int row);
        bit seen;
        logic [31:0] addr_seen;
        logic [31:0] wen_seen;
        seen      = 1'b0;
        addr_seen = '0;
        wen_seen  = '0;
        wr_req    = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (wr_ack) begin
                seen      = 1'b1;
                addr_seen = 32'(fifo_addr);
                wen_seen  = 32'(fifo_w_en);
            end
        end
        wr_req = 1'b0;
        check("wr_ack_seen", 32'(seen), 1);
        check("wr_w_en", wen_seen, 1);
        check("wr_addr", addr_seen, 32'(row));
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Global time bound so the bench can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int ren_cyc;
        int sv_cyc;
        int first_sv;
        int last_sv;
        int addr_err;
        int busy18;
        int ack_cyc;
        int ack_addr;
        int early_ack;

        tests   = 0;
        failed  = 0;
        reset_n = 1'b0;
        clr     = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_w_en", 32'(fifo_w_en), 0);
        check("rst_r_en", 32'(fifo_r_en), 0);
        check("rst_wr_ack", 32'(wr_ack), 0);
        check("rst_sv", 32'(sample_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_addr", 32'(fifo_addr), 0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Three row writes at rows 0,1,2
        for (int r = 0; r < 3; r++) do_write(r);
        check("w3_count", 32'(count), 3);
        check("w3_empty", 32'(empty), 0);
        check("w3_full", 32'(full), 0);

        // Two-row read burst
        pulse_clr();
        do_write(0);
        do_write(1);
        ren_cyc = 0; sv_cyc = 0; first_sv = 0; last_sv = 0; addr_err = 0; busy18 = -1;
        rd_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (fifo_r_en) ren_cyc++;
            if (sample_valid) begin
                sv_cyc++;
                if (first_sv == 0) first_sv = i;
                last_sv = i;
            end
            if (i <= 8 && fifo_addr != 7'd0) addr_err++;
            if (i >= 9 && i <= 16 && fifo_addr != 7'd1) addr_err++;
            if (i == 18) busy18 = int'(busy);
        end
        rd_req = 1'b0;
        check("rd2_ren_cycles", 32'(ren_cyc), 17);
        check("rd2_sv_cycles", 32'(sv_cyc), 16);
        check("rd2_first_sv", 32'(first_sv), 2);
        check("rd2_last_sv", 32'(last_sv), 17);
        check("rd2_addr_errs", 32'(addr_err), 0);
        check("rd2_busy_c18", 32'(busy18), 0);
        check("rd2_count", 32'(count), 0);
        check("rd2_empty", 32'(empty), 1);

        // Write arriving during a three-row burst
        pulse_clr();
        for (int r = 0; r < 3; r++) do_write(r);
        ack_cyc = 0; ack_addr = -1;
        rd_req = 1'b1;
        for (int i = 1; i <= 60 && ack_cyc == 0; i++) begin
            @(negedge clk);
            if (wr_ack) begin
                ack_cyc  = i;
                ack_addr = int'(fifo_addr);
            end
            if (i == 3) wr_req = 1'b1;
        end
        wr_req = 1'b0;
        check("prio_ack_cycle", 32'(ack_cyc), 32'(EXP_ACK_CYC));
        check("prio_ack_addr", 32'(ack_addr), 3);
        repeat (2) @(negedge clk);
        check("prio_resume_ren", 32'(fifo_r_en), 1);
        check("prio_resume_addr", 32'(fifo_addr), 32'(EXP_RESUME));
        rd_req = 1'b0;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("prio_idle", 32'(busy), 0);

        // Fill to full, stall a write, free one row, write wraps to row 0
        pulse_clr();
        for (int r = 0; r < 128; r++) do_write(r);
        check("full_flag", 32'(full), 1);
        check("full_count", 32'(count), 128);
        check("full_empty", 32'(empty), 0);
        wr_req = 1'b1;
        early_ack = 0;
        repeat (6) begin
            @(negedge clk);
            if (wr_ack) early_ack++;
        end
        check("full_no_ack", 32'(early_ack), 0);
        check("full_stall_idle", 32'(busy), 0);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        check("full_rd_ren", 32'(fifo_r_en), 1);
        check("full_rd_addr", 32'(fifo_addr), 0);
        ack_cyc = 0; ack_addr = -1;
        for (int i = 1; i <= 40 && ack_cyc == 0; i++) begin
            @(negedge clk);
            if (wr_ack) begin
                ack_cyc  = i;
                ack_addr = int'(fifo_addr);
            end
        end
        wr_req = 1'b0;
        check("wrap_ack_cycle", 32'(ack_cyc), 10);
        check("wrap_ack_addr", 32'(ack_addr), 0);
        @(negedge clk);
        check("wrap_count", 32'(count), 128);
        check("wrap_full", 32'(full), 1);

        // clr in the 4th read cycle
        rd_req = 1'b1;
        repeat (4) @(negedge clk);
        check("clr_pre_ren", 32'(fifo_r_en), 1);
        check("clr_pre_addr", 32'(fifo_addr), 1);
        clr = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
        rd_req = 1'b0;
        check("clr_ren", 32'(fifo_r_en), 0);
        check("clr_sv", 32'(sample_valid), 0);
        check("clr_count", 32'(count), 0);
        check("clr_empty", 32'(empty), 1);
        check("clr_busy", 32'(busy), 0);
        check("clr_addr", 32'(fifo_addr), 0);
        do_write(0);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        check("clr_rdptr_addr", 32'(fifo_addr), 0);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("clr_rd_done", 32'(count), 0);

        // Async reset in the middle of a WRITE cycle
        do_write(1);
        wr_req = 1'b1;
        @(negedge clk);
        check("arst_pre_ack", 32'(wr_ack), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_w_en", 32'(fifo_w_en), 0);
        check("arst_wr_ack", 32'(wr_ack), 0);
        check("arst_addr", 32'(fifo_addr), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_count", 32'(count), 0);
        wr_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("arst_post_count", 32'(count), 0);
        check("arst_post_empty", 32'(empty), 1);
        check("arst_post_ack", 32'(wr_ack), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
